// File: rtl/pcie_cfg_mgmt_pkg.sv
// Shared types and field constants for the cfg_mgmt responder.
package pcie_cfg_mgmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE,
        ST_GAP
    } cfg_state_e;

    localparam int CFG_ADDR_W   = 10;
    localparam int CFG_FUNC_LSB = 10;
    localparam int CFG_FUNC_W   = 8;
    localparam int CFG_RSVD_BIT = 18;
    localparam int LAT_CNT_W    = 4;

    // Request captured in the IDLE sample cycle; bad covers out-of-range and read+write.
    typedef struct packed {
        logic        wr;
        logic        oor;
        logic        bad;
        logic [3:0]  be;
        logic [31:0] data;
    } cfg_req_t;

endpackage

// File: rtl/pcie_cfg_mgmt_regfile.sv
// Byte-enabled dword register file with registered read and a forced-value read path.
module pcie_cfg_mgmt_regfile #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [3:0]            wr_be,
    input  logic [31:0]           wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    input  logic                  rd_force,
    input  logic [31:0]           rd_force_val,
    output logic [31:0]           rd_data
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH-1:0][31:0] mem_q, mem_d;
    logic [31:0]            rd_data_q, rd_data_d;

    always_comb begin
        mem_d     = mem_q;
        rd_data_d = rd_data_q;
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
            end
        end
        if (rd_en) rd_data_d = rd_force ? rd_force_val : mem_q[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q     <= '0;
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pcie_cfg_mgmt_responder.sv
// cfg_mgmt responder: fixed-latency dword read/write into a small register file.
// Optional read-only ID at dword 0 when CFG_MGMT_ID_LOCK_EN is defined.
module pcie_cfg_mgmt_responder
    import pcie_cfg_mgmt_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 6,
    parameter int          LATENCY    = 4,
    parameter logic [31:0] ID_VALUE   = 32'h7038_10EE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] cfg_mgmt_addr,
    input  logic        cfg_mgmt_write,
    input  logic [31:0] cfg_mgmt_write_data,
    input  logic [3:0]  cfg_mgmt_byte_enable,
    input  logic        cfg_mgmt_read,
    output logic [31:0] cfg_mgmt_read_data,
    output logic        cfg_mgmt_read_write_done,
    output logic        bad_access
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    // Counter starts at LATENCY-2 so DONE is entered LATENCY-1 edges after the sample edge.
    localparam logic [LAT_CNT_W-1:0] LAT_INIT =
        (LATENCY > 1) ? LAT_CNT_W'(LATENCY - 2) : '0;
`ifdef CFG_MGMT_ID_LOCK_EN
    localparam bit ID_LOCK = 1'b1;
`else
    localparam bit ID_LOCK = 1'b0;
`endif

    cfg_state_e            state_q, state_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    cfg_req_t              req_q, req_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  done_q, done_d;
    logic                  bad_q, bad_d;

    logic in_oor, wr_en, rd_en, rd_id_hit, wr_id_hit;

    assign in_oor = (32'(cfg_mgmt_addr[CFG_ADDR_W-1:0]) >= DEPTH)
                  || (cfg_mgmt_addr[CFG_FUNC_LSB +: CFG_FUNC_W] != '0)
                  || cfg_mgmt_addr[CFG_RSVD_BIT];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_mgmt_write || cfg_mgmt_read) begin
                    req_d.wr   = cfg_mgmt_write;
                    req_d.oor  = in_oor;
                    req_d.bad  = in_oor || (cfg_mgmt_write && cfg_mgmt_read);
                    req_d.be   = cfg_mgmt_byte_enable;
                    req_d.data = cfg_mgmt_write_data;
                    idx_d      = cfg_mgmt_addr[DEPTH_LOG2-1:0];
                    cnt_d      = LAT_INIT;
                    state_d    = (LATENCY == 1) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - LAT_CNT_W'(1);
            end
            ST_DONE: state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
        bad_d  = done_d && req_d.bad;
    end

    // Read data is loaded on the edge entering DONE, so it uses the next-state request view.
    assign rd_id_hit = ID_LOCK && (idx_d == '0) && !req_d.oor;
    assign rd_en     = done_d && !req_d.wr;
    assign wr_id_hit = ID_LOCK && (idx_q == '0);
    assign wr_en     = (state_q == ST_DONE) && req_q.wr && !req_q.oor && !wr_id_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
        end
    end

    pcie_cfg_mgmt_regfile #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_idx      (idx_q),
        .wr_be       (req_q.be),
        .wr_data     (req_q.data),
        .rd_en       (rd_en),
        .rd_idx      (idx_d),
        .rd_force    (req_d.oor || rd_id_hit),
        .rd_force_val(req_d.oor ? 32'h0 : ID_VALUE),
        .rd_data     (cfg_mgmt_read_data)
    );

    assign cfg_mgmt_read_write_done = done_q;
    assign bad_access               = bad_q;

endmodule

// File: tb/tb_pcie_cfg_mgmt_responder.sv
// Directed bench for pcie_cfg_mgmt_responder (default parameters).
module tb_pcie_cfg_mgmt_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] addr = '0;
    logic        wr = 1'b0, rd = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata_o;
    logic        done_o, bad_o;

    int n_vec = 0, n_err = 0;
    int cyc = 0, done_cnt = 0, bad_cnt = 0;
    int done_t[$];

`ifdef CFG_MGMT_ID_LOCK_EN
    localparam logic [31:0] EXP_DW0_A = 32'h7038_10EE;
    localparam logic [31:0] EXP_DW0_B = 32'h7038_10EE;
    localparam logic [31:0] EXP_DW0_Z = 32'h7038_10EE;
`else
    localparam logic [31:0] EXP_DW0_A = 32'h0BAD_F00D;
    localparam logic [31:0] EXP_DW0_B = 32'h0000_0000;
    localparam logic [31:0] EXP_DW0_Z = 32'h0000_0000;
`endif

    pcie_cfg_mgmt_responder dut (
        .clk                     (clk),
        .rst                     (rst),
        .cfg_mgmt_addr           (addr),
        .cfg_mgmt_write          (wr),
        .cfg_mgmt_write_data     (wdata),
        .cfg_mgmt_byte_enable    (be),
        .cfg_mgmt_read           (rd),
        .cfg_mgmt_read_data      (rdata_o),
        .cfg_mgmt_read_write_done(done_o),
        .bad_access              (bad_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (done_o) begin
            done_cnt++;
            done_t.push_back(cyc);
        end
        if (bad_o) bad_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One transfer: lat counts edges from the sample edge to the edge that sees done.
    task automatic xfer(input logic w, input logic r, input logic [18:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output logic [31:0] rdat, output int lat,
                        output logic bad, output int nd, output int nb);
        int  d0, b0;
        bit  seen;
        d0 = done_cnt; b0 = bad_cnt; seen = 0; lat = 0; rdat = '0; bad = 1'b0;
        @(negedge clk);
        addr = a; wr = w; rd = r; wdata = d; be = b;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done_o) begin
                seen = 1; rdat = rdata_o; bad = bad_o;
                break;
            end
            @(posedge clk);
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        wr = 1'b0; rd = 1'b0; be = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        nd = done_cnt - d0;
        nb = bad_cnt - b0;
    endtask

    initial begin
        logic [31:0] rdat, prev;
        logic        bad;
        int          lat, nd, nb, d0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'd0);
        chk("rst_bad", {31'b0, bad_o}, 32'd0);
        rst = 1'b0;

        xfer(1, 0, 19'd5, 32'hDEAD_BEEF, 4'hF, rdat, lat, bad, nd, nb);
        chk("wr5_lat", 32'(lat), 32'd4);
        chk("wr5_bad", {31'b0, bad}, 32'd0);
        chk("wr5_ndone", 32'(nd), 32'd1);
        xfer(0, 1, 19'd5, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("rd5_lat", 32'(lat), 32'd4);
        chk("rd5_data", rdat, 32'hDEAD_BEEF);

        xfer(1, 0, 19'd5, 32'h1122_3344, 4'b0101, rdat, lat, bad, nd, nb);
        xfer(0, 1, 19'd5, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("rd5_partial", rdat, 32'hDE22_BE44);
        chk("rd5_hold", rdata_o, 32'hDE22_BE44);

        xfer(1, 0, 19'd5, 32'hFFFF_FFFF, 4'h0, rdat, lat, bad, nd, nb);
        chk("be0_ndone", 32'(nd), 32'd1);
        chk("be0_bad", {31'b0, bad}, 32'd0);
        xfer(0, 1, 19'd5, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("rd5_be0", rdat, 32'hDE22_BE44);

        xfer(0, 1, 19'd64, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("oor64_data", rdat, 32'h0);
        chk("oor64_bad", {31'b0, bad}, 32'd1);
        chk("oor64_ndone", 32'(nd), 32'd1);
        chk("oor64_nbad", 32'(nb), 32'd1);
        xfer(0, 1, 19'h00405, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("func1_data", rdat, 32'h0);
        chk("func1_ndone", 32'(nd), 32'd1);
        chk("func1_nbad", 32'(nb), 32'd1);
        xfer(0, 1, 19'h40005, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("rsvd_data", rdat, 32'h0);
        chk("rsvd_bad", {31'b0, bad}, 32'd1);

        xfer(1, 0, 19'd64, 32'h1234_5678, 4'hF, rdat, lat, bad, nd, nb);
        chk("oorwr_bad", {31'b0, bad}, 32'd1);
        xfer(0, 1, 19'd0, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("oorwr_dropped", rdat, EXP_DW0_Z);

        xfer(1, 0, 19'd0, 32'h0BAD_F00D, 4'hF, rdat, lat, bad, nd, nb);
        chk("dw0_wr_bad", {31'b0, bad}, 32'd0);
        xfer(0, 1, 19'd0, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("dw0_rd_a", rdat, EXP_DW0_A);
        xfer(1, 0, 19'd0, 32'h0, 4'hF, rdat, lat, bad, nd, nb);
        chk("dw0_wr0_ndone", 32'(nd), 32'd1);
        xfer(0, 1, 19'd0, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("dw0_rd_b", rdat, EXP_DW0_B);

        xfer(0, 1, 19'd5, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        prev = rdat;
        xfer(1, 1, 19'd3, 32'hA5A5_A5A5, 4'hF, rdat, lat, bad, nd, nb);
        chk("both_ndone", 32'(nd), 32'd1);
        chk("both_nbad", 32'(nb), 32'd1);
        chk("both_rd_unchanged", rdat, prev);
        xfer(0, 1, 19'd3, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("both_rd3", rdat, 32'hA5A5_A5A5);

        // Reset lands on the second edge after the sample edge, before DONE.
        d0 = done_cnt;
        @(negedge clk);
        addr = 19'd7; wr = 1'b1; wdata = 32'h55AA_55AA; be = 4'hF;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; wr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rdata", rdata_o, 32'h0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("rst_mid_nodone", 32'(done_cnt - d0), 32'd0);
        xfer(0, 1, 19'd7, 32'h0, 4'h0, rdat, lat, bad, nd, nb);
        chk("rst_mid_rd7", rdat, 32'h0);

        // Request held continuously: accepted every LATENCY+2 cycles.
        done_t.delete();
        @(negedge clk);
        addr = 19'd1; rd = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rd = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("held_count", 32'(done_t.size()), 32'd4);
        if (done_t.size() >= 4) begin
            for (int i = 1; i < 4; i++)
                chk($sformatf("held_period%0d", i), 32'(done_t[i] - done_t[i-1]), 32'd6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
